// File: rtl/ysyx_25040111_axi_mem.sv
// Single-beat AXI4-Lite-style memory responder with independent read/write FSMs.
// Define AXI_MEM_DELAY_EN to add a 0..7 cycle LFSR-driven delay before each response.
module ysyx_25040111_axi_mem #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int          DEPTH       = 1 << DEPTH_LOG2;
  localparam logic [31:0] SPAN        = 32'd4 << DEPTH_LOG2;
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_WAIT, W_RESP} w_state_e;

  // Handshake rule: a transfer happens on a rising edge where valid && ready.
  r_state_e r_state_q, r_state_d;
  w_state_e w_state_q, w_state_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [1:0]  bresp_q, bresp_d;
  logic [DEPTH_LOG2-1:0] widx_q, widx_d;
  logic win_q, win_d;

  logic [31:0] mem [DEPTH];

  logic [31:0] ar_off, aw_off;
  logic ar_in_range, aw_in_range;
  logic [DEPTH_LOG2-1:0] ar_idx, aw_idx;
  logic ar_hs, w_commit;

  assign ar_off      = araddr - BASE_ADDR;
  assign aw_off      = awaddr - BASE_ADDR;
  assign ar_in_range = ar_off < SPAN;
  assign aw_in_range = aw_off < SPAN;
  assign ar_idx      = ar_off[DEPTH_LOG2+1:2];
  assign aw_idx      = aw_off[DEPTH_LOG2+1:2];

  assign arready = (r_state_q == R_IDLE);
  assign rvalid  = (r_state_q == R_RESP);
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;
  assign awready = (w_state_q == W_IDLE);
  assign wready  = (w_state_q == W_DATA);
  assign bvalid  = (w_state_q == W_RESP);
  assign bresp   = bresp_q;

  assign ar_hs    = arvalid && (r_state_q == R_IDLE);
  assign w_commit = wvalid && (w_state_q == W_DATA);

  logic [2:0] r_dly, w_dly;
  logic       r_wait_done, w_wait_done;

`ifdef AXI_MEM_DELAY_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic [2:0] rcnt_q, rcnt_d, wcnt_q, wcnt_d;

  assign lfsr_d      = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign r_dly       = lfsr_q[2:0];
  assign w_dly       = lfsr_q[5:3];
  // A count of n keeps the FSM in WAIT for exactly n cycles.
  assign r_wait_done = (rcnt_q == 3'd1);
  assign w_wait_done = (wcnt_q == 3'd1);

  always_comb begin
    rcnt_d = rcnt_q;
    wcnt_d = wcnt_q;
    if (ar_hs) rcnt_d = r_dly;
    else if (r_state_q == R_WAIT) rcnt_d = rcnt_q - 3'd1;
    if (w_commit) wcnt_d = w_dly;
    else if (w_state_q == W_WAIT) wcnt_d = wcnt_q - 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
      rcnt_q <= 3'd0;
      wcnt_q <= 3'd0;
    end else begin
      lfsr_q <= lfsr_d;
      rcnt_q <= rcnt_d;
      wcnt_q <= wcnt_d;
    end
  end
`else
  assign r_dly       = 3'd0;
  assign w_dly       = 3'd0;
  assign r_wait_done = 1'b1;
  assign w_wait_done = 1'b1;
`endif

  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (arvalid) begin
          // Array read here sees the pre-write value on a same-edge W commit.
          rdata_d   = ar_in_range ? mem[ar_idx] : 32'd0;
          rresp_d   = ar_in_range ? RESP_OKAY : RESP_SLVERR;
          r_state_d = (r_dly != 3'd0) ? R_WAIT : R_RESP;
        end
      end
      R_WAIT: if (r_wait_done) r_state_d = R_RESP;
      R_RESP: if (rready) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_d = w_state_q;
    widx_d    = widx_q;
    win_d     = win_q;
    bresp_d   = bresp_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (awvalid) begin
          widx_d    = aw_idx;
          win_d     = aw_in_range;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (wvalid) begin
          bresp_d   = win_q ? RESP_OKAY : RESP_SLVERR;
          w_state_d = (w_dly != 3'd0) ? W_WAIT : W_RESP;
        end
      end
      W_WAIT: if (w_wait_done) w_state_d = W_RESP;
      W_RESP: if (bready) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      w_state_q <= W_IDLE;
      rdata_q   <= 32'd0;
      rresp_q   <= RESP_OKAY;
      bresp_q   <= RESP_OKAY;
      widx_q    <= '0;
      win_q     <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      w_state_q <= w_state_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      bresp_q   <= bresp_d;
      widx_q    <= widx_d;
      win_q     <= win_d;
    end
  end

  // Storage is deliberately not reset; reset keeps the write FSM out of W_DATA.
  always_ff @(posedge clk) begin
    if (w_commit && win_q) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[widx_q][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_axi_mem.sv
// Directed plus randomized bench for ysyx_25040111_axi_mem against a word-array memory model.
module tb_ysyx_25040111_axi_mem;

  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  ysyx_25040111_axi_mem dut (
    .clk(clk), .rst_n(rst_n),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  bit [7:0] lat_seen = '0;
  logic [31:0] mdl [int unsigned];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit in_rng(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < 32'h1000;
  endfunction

  function automatic void mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int unsigned i;
    logic [31:0] w;
    if (in_rng(a)) begin
      i = (a - BASE) >> 2;
      w = mdl.exists(i) ? mdl[i] : 32'd0;
      for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
      mdl[i] = w;
    end
  endfunction

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    if (!in_rng(a)) return 32'd0;
    return mdl[(a - BASE) >> 2];
  endfunction

  task automatic note_lat(input string tag, input int lat);
`ifdef AXI_MEM_DELAY_EN
    check(tag, lat <= 7, 1);
    if (lat < 8) lat_seen[lat] = 1'b1;
`else
    check(tag, lat, 0);
`endif
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [1:0] resp);
    int n;
    int lat;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1;
    n = 0;
    while (!awready && n < 50) begin tick(); n++; end
    check("aw_ready", awready, 1);
    tick();
    awvalid = 1'b0;
    n = 0;
    while (!wready && n < 50) begin tick(); n++; end
    check("w_ready", wready, 1);
    tick();
    wvalid = 1'b0;
    lat = 0;
    while (!bvalid && lat < 50) begin tick(); lat++; end
    check("b_valid", bvalid, 1);
    note_lat("wr_lat", lat);
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
    mdl_write(a, d, s);
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    int lat;
    araddr = a; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 50) begin tick(); n++; end
    check("ar_ready", arready, 1);
    tick();
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 50) begin tick(); lat++; end
    check("r_valid", rvalid, 1);
    note_lat("rd_lat", lat);
    d = rdata;
    resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  task automatic wait_both();
    int n;
    n = 0;
    while (!(rvalid && bvalid) && n < 50) begin tick(); n++; end
    check("both_valid", rvalid && bvalid, 1);
  endtask

  initial begin
    logic [31:0] a, d, got, exp_d;
    logic [3:0]  s;
    logic [1:0]  r;

    // Reset with requests pending: nothing may be taken while rst_n is low.
    #2;
    rst_n = 1'b0;
    arvalid = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    tick();
    check("rst_rvalid", rvalid, 0);
    check("rst_bvalid", bvalid, 0);
    check("rst_wready", wready, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rresp", rresp, 0);
    check("rst_bresp", bresp, 0);
    check("rst_arready", arready, 1);
    check("rst_awready", awready, 1);
    tick();
    check("rst_hold_rvalid", rvalid, 0);
    check("rst_hold_wready", wready, 0);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    rst_n = 1'b1;
    tick();

    // Full word write and readback.
    do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, r);
    check("wr1_bresp", r, 2'b00);
    do_read(BASE + 32'h10, got, r);
    check("rd1_data", got, 32'hDEAD_BEEF);
    check("rd1_rresp", r, 2'b00);

    // Byte-lane merge.
    do_write(BASE + 32'h10, 32'h0000_AA00, 4'b0010, r);
    check("wr2_bresp", r, 2'b00);
    do_read(BASE + 32'h10, got, r);
    check("rd2_data", got, 32'hDEAD_AAEF);
    check("rd2_rresp", r, 2'b00);
    do_read(BASE + 32'h13, got, r);
    check("rd_lowbits_data", got, 32'hDEAD_AAEF);

    // Range boundaries and dropped out-of-range writes.
    do_write(BASE, 32'h1234_5678, 4'hF, r);
    check("wr_base_bresp", r, 2'b00);
    do_read(BASE + 32'h1000, got, r);
    check("rd_oob_data", got, 32'd0);
    check("rd_oob_rresp", r, 2'b10);
    do_write(BASE + 32'h1000, 32'hFFFF_FFFF, 4'hF, r);
    check("wr_oob_bresp", r, 2'b10);
    do_read(BASE, got, r);
    check("rd_base_unchanged", got, 32'h1234_5678);
    do_read(BASE - 32'd4, got, r);
    check("rd_below_rresp", r, 2'b10);
    check("rd_below_data", got, 32'd0);
    do_write(BASE + 32'hFFC, 32'hA5A5_0FFC, 4'hF, r);
    check("wr_last_bresp", r, 2'b00);
    do_read(BASE + 32'hFFC, got, r);
    check("rd_last_data", got, 32'hA5A5_0FFC);
    check("rd_last_rresp", r, 2'b00);
    do_write(BASE, 32'hFFFF_FFFF, 4'b0000, r);
    check("wr_nostrb_bresp", r, 2'b00);
    do_read(BASE, got, r);
    check("rd_nostrb_data", got, 32'h1234_5678);

    // Backpressure on both channels at once.
    araddr = BASE + 32'h10; arvalid = 1'b1;
    awaddr = BASE + 32'h30; awvalid = 1'b1;
    wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    arvalid = 1'b0; awvalid = 1'b0;
    check("bp_wready", wready, 1);
    tick();
    wvalid = 1'b0;
    mdl_write(BASE + 32'h30, 32'hCAFE_F00D, 4'hF);
    wait_both();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rvalid", rvalid, 1);
      check("bp_bvalid", bvalid, 1);
      check("bp_rdata", rdata, 32'hDEAD_AAEF);
      check("bp_rresp", rresp, 2'b00);
      check("bp_bresp", bresp, 2'b00);
      check("bp_arready", arready, 0);
      check("bp_awready", awready, 0);
    end
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    check("bp_arready_back", arready, 1);
    check("bp_awready_back", awready, 1);
    check("bp_rvalid_drop", rvalid, 0);
    check("bp_bvalid_drop", bvalid, 0);
    do_read(BASE + 32'h30, got, r);
    check("bp_wr_data", got, 32'hCAFE_F00D);

    // Same-edge AR handshake and W commit to one word.
    do_write(BASE + 32'h20, 32'h1111_1111, 4'hF, r);
    awaddr = BASE + 32'h20; awvalid = 1'b1;
    wdata = 32'h2222_2222; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    check("col_wready", wready, 1);
    araddr = BASE + 32'h20; arvalid = 1'b1;
    check("col_arready", arready, 1);
    tick();
    arvalid = 1'b0; wvalid = 1'b0;
    mdl_write(BASE + 32'h20, 32'h2222_2222, 4'hF);
    wait_both();
    check("col_old_data", rdata, 32'h1111_1111);
    check("col_bresp", bresp, 2'b00);
    rready = 1'b1; bready = 1'b1;
    tick();
    rready = 1'b0; bready = 1'b0;
    do_read(BASE + 32'h20, got, r);
    check("col_new_data", got, 32'h2222_2222);

    // Reset between AW and W: the pending commit must not happen.
    do_write(BASE + 32'h40, 32'h5555_AAAA, 4'hF, r);
    awaddr = BASE + 32'h40; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wdata = 32'h0; wstrb = 4'hF; wvalid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_wready", wready, 0);
    tick();
    rst_n = 1'b1;
    wvalid = 1'b0;
    tick();
    do_read(BASE + 32'h40, got, r);
    check("rst_mid_data", got, 32'h5555_AAAA);

    // Randomized traffic over a small window plus out-of-range addresses.
    for (int i = 0; i < 16; i++) begin
      do_write(BASE + 32'(i * 4), $urandom, 4'hF, r);
    end
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 1) a = BASE + 32'h1000 + 32'($urandom_range(0, 4095));
        else a = BASE - 32'd1 - 32'($urandom_range(0, 4095));
      end else begin
        a = BASE + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, r);
        check("rnd_bresp", r, in_rng(a) ? 2'b00 : 2'b10);
      end else begin
        exp_d = mdl_read(a);
        do_read(a, got, r);
        check("rnd_rdata", got, exp_d);
        check("rnd_rresp", r, in_rng(a) ? 2'b00 : 2'b10);
      end
    end

`ifdef AXI_MEM_DELAY_EN
    check("lat_span", lat_seen, 8'hFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
